photon_count_sample_fifo: RTL
=============================

// Module: photon_count_sample_fifo
// PURPOSE
//  Downstream stage of the photon pulse counter. Captures each 8-digit BCD count word on the
//  counter's one-cycle data_update strobe and tags it with an 8-bit sequence number and a
//  BCD-validity flag. Buffers tagged samples in a first-word-fall-through FIFO and presents them
//  on a valid/ready stream to the TFT display / host readout logic. Drops are detectable
//  through sequence gaps and a saturating drop counter.
// PARAMETERS
//  DEPTH      16   FIFO entries; power of two, 2..256
//  AW         4    address width = log2(DEPTH)
//  DROP_W     16   width of saturating drop counter
// PORTS
//  clk          in   1       system clock, all logic rising-edge
//  rst          in   1       synchronous reset, active-high
//  en           in   1       capture enable; gates pushes only, pops always allowed
//  data_update  in   1       one-cycle strobe from pulse counter: din is a new sample
//  din          in   32      8 BCD digits, din[3:0] = least significant digit
//  m_valid      out  1       head entry available (FWFT)
//  m_ready      in   1       consumer accepts head entry this cycle
//  m_data       out  32      head sample BCD word
//  m_seq        out  8       head sample sequence tag
//  m_bad_bcd    out  1       head sample had at least one nibble > 9
//  level        out  AW+1    current occupancy, 0..DEPTH
//  full         out  1       level == DEPTH
//  empty        out  1       level == 0
//  drop_cnt     out  DROP_W  samples lost because FIFO full, saturating
// BEHAVIOUR
//  Reset (rst=1 at posedge): wr/rd pointers=0, level=0, empty=1, full=0, m_valid=0, seq=0,
//   drop_cnt=0; m_data/m_seq/m_bad_bcd don't-care while m_valid=0. Mid-operation reset discards
//   all stored samples and takes effect the same edge.
//  push_req = en & data_update. pop = m_valid & m_ready.
//  push = push_req & (!full | pop): simultaneous push+pop when full is accepted, level holds.
//  Stored entry = {bad_bcd, seq, din}, 41 bits. bad_bcd = OR over nibbles of (nibble > 4'd9).
//  seq: 8-bit counter, increments (wraps 255->0) on every push_req, accepted or dropped.
//   The entry carries the pre-increment value; a gap in m_seq equals the number of drops.
//  Drop: push_req & full & !pop -> entry not written, drop_cnt += 1, saturates at all-ones.
//  level: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo
//   DEPTH. full/empty are derived from level and are registered consistently with it.
//  Latency: push into empty FIFO at edge N -> m_valid=1 and head data valid after edge N.
//   Pop at edge N -> next entry (or m_valid=0) visible after edge N.
//  Head outputs are stable while m_valid=1 & m_ready=0 (AXI-style; no retraction).
//  en=0: push_req forced 0; seq and drop_cnt hold; the FIFO keeps draining.
//  data_update is a single-cycle strobe. Back-to-back strobes are each treated as a separate
//   sample.
//  Storage may be distributed RAM or a register array. No combinational path from m_ready to m_valid.
// TESTING
//  T1 reset, push din=32'h0000_1234 -> 1 cycle later m_valid=1, m_data=32'h1234, m_seq=0,
//     m_bad_bcd=0, level=1.
//  T2 m_ready=0, push 16 samples -> full=1, level=16. 17th strobe -> drop_cnt=1, level=16.
//     Drain all -> m_seq 0..15, then next push carries m_seq=17.
//  T3 full, push+pop same cycle -> level stays 16, drop_cnt unchanged, new entry at tail.
//  T4 din=32'h0000_00A5 -> m_bad_bcd=1. din=32'h9999_9999 -> m_bad_bcd=0.
//  T5 300 pushes with continuous drain -> m_seq wraps 255->0 and no drops.
//     Force 70000 drops -> drop_cnt saturates at 16'hFFFF.
//  T6 en=0 with strobes -> no push, seq holds. Assert rst with 5 entries queued -> next cycle
//     level=0, m_valid=0, drop_cnt=0.

Source files
------------

// File: rtl/photon_count_sample_fifo.sv
// photon_count_sample_fifo
// Captures BCD count words from the pulse counter and tags each one with a
// sequence number and a BCD-validity flag. Samples are queued in a
// first-word-fall-through FIFO and offered on a valid/ready stream.
// A full FIFO drops samples: the sequence tag still advances, so gaps in
// m_seq show losses, and drop_cnt counts them (saturating).
module photon_count_sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              data_update,
    input  logic [31:0]       din,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,
    output logic [7:0]        m_seq,
    output logic              m_bad_bcd,
    output logic [AW:0]       level,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int ENTRY_W = 41;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    // A word is malformed if any of its eight digits is above 9.
    function automatic logic bcd_bad(input logic [31:0] d);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (d[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        if (&v) return v;
        return v + {{(DROP_W-1){1'b0}}, 1'b1};
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        level_q;
    logic [AW:0]        level_next;
    logic               full_q;
    logic               empty_q;
    logic [7:0]         seq;
    logic [DROP_W-1:0]  drop_q;
    logic               push_req;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Handshake decode; pop only looks at registered state, so m_ready
    // never reaches m_valid combinationally. A full FIFO still accepts a
    // push when the head leaves in the same cycle.
    always_comb begin
        push_req   = en & data_update;
        pop        = ~empty_q & m_ready;
        push       = push_req & (~full_q | pop);
        drop       = push_req & full_q & ~pop;
        level_next = level_q;
        if (push && !pop)      level_next = level_q + LVL_ONE;
        else if (pop && !push) level_next = level_q - LVL_ONE;
    end

    // Control state: pointers, occupancy, flags, sequence tag, drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            seq     <= 8'd0;
            drop_q  <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            if (push_req) seq    <= seq + 8'd1;
            if (drop)     drop_q <= sat_inc(drop_q);
            level_q <= level_next;
            full_q  <= (level_next == LVL_FULL);
            empty_q <= (level_next == '0);
        end
    end

    // Sample storage; entries carry the tag value from before this strobe.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bcd_bad(din), seq, din};
    end

    assign head      = mem[rd_ptr];
    assign m_valid   = ~empty_q;
    assign m_bad_bcd = head[40];
    assign m_seq     = head[39:32];
    assign m_data    = head[31:0];
    assign level     = level_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign drop_cnt  = drop_q;

endmodule
